booth_seq_ctrl: RTL
===================

BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width N in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH bits: multiplier, signed two's complement.
REQ-006 SHALL have port M, input, WIDTH bits: multiplicand, signed two's complement.
REQ-007 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port P, output, 2*WIDTH bits: signed product, registered.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 SHALL, in IDLE with start=1, capture A and M, clear the accumulator, set step count=0 and Q(-1)=0, and go to RUN.
REQ-012 SHALL, in RUN, perform one radix-2 Booth step per cycle:
  - {Q0,Q-1}=01: add M.
  - {Q0,Q-1}=10: subtract M.
  - 00 or 11: no add.
  - Then arithmetic right shift of {acc,Q,Q-1}.
REQ-013 SHALL hold the accumulator at WIDTH+1 bits, so that M = -2^(WIDTH-1) multiplies correctly.
REQ-014 SHALL, after exactly WIDTH RUN steps, load P with the low 2*WIDTH bits of {acc,Q} and go to DONE.
REQ-015 SHALL make done a registered output, high only while in DONE, which lasts exactly one cycle and then returns to IDLE.
REQ-016 SHALL give a latency of WIDTH cycles: done is high in the WIDTH-th cycle after the accept edge.
REQ-017 SHALL ignore start while in RUN or DONE, with no queuing.
REQ-018 SHALL accept a start held high continuously again in the cycle after DONE (back-to-back throughput of one result per WIDTH+1 cycles).
REQ-019 SHALL hold P stable from done until the next result load, and SHALL NOT disturb P while RUN is in progress.
REQ-020 SHALL ignore changes on A and M after the accept edge.

Reset
REQ-021 SHALL, on rst_n=0, immediately set state=IDLE, busy=0, done=0, P=0, and clear the accumulator, Q, Q-1 and the step count, including mid-RUN; the aborted operation produces no done.
REQ-022 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-023 SHALL implement the zero-shortcut feature under macro BOOTH_ZERO_SHORTCUT_EN.
  - Defined: in IDLE with start=1 and A==0 or M==0, SHALL set P=0 and go directly to DONE, so done is high in the cycle after the accept edge.
  - Undefined: every operation SHALL take the full RUN path with WIDTH-cycle latency, and zero operands SHALL still give P=0.

Structure
REQ-024 SHALL take the FSM state enum (IDLE/RUN/DONE) and the default width constant from shared package booth_pkg.
REQ-025 SHALL implement the combinational add/sub plus arithmetic-shift step as sub-module booth_step, instantiated once; booth_seq_ctrl holds the FSM, the counter and the registers.

Verification
REQ-026 SHALL cover A=1101, M=1011 (-3*-5): done after 4 cycles, P=8'h0F.
REQ-027 SHALL cover A=1001, M=0001, then A=0111, M=1111: P=8'hF9 both times.
REQ-028 SHALL cover A=1010, M=0010 (-6*2): P=8'hF4. It SHALL also cover A=1000, M=1000 (-8*-8): P=8'h40.
REQ-029 SHALL cover a start pulse mid-RUN: it is ignored, with exactly one done and the P of the first operation.
REQ-030 SHALL cover rst_n=0 in the 2nd RUN cycle: busy=0, P=0 and done=0 immediately, and a following start of 0011*0011 gives P=8'h09.
REQ-031 SHALL cover A=0000, M=0101:
  - P=0 in all builds.
  - With BOOTH_ZERO_SHORTCUT_EN defined, done in the cycle after accept.
  - With it undefined, done after 4 cycles.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
// Holds the FSM state encoding and the default operand width.
package booth_pkg;

   localparam int BOOTH_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/sub of M, then arithmetic right shift of {acc,Q,Q-1}.
// Purely combinational; the accumulator is one bit wider than the operands so -2^(WIDTH-1) negates cleanly.
module booth_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] q,
   input  logic             q_m1,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH:0]   acc_nxt,
   output logic [WIDTH-1:0] q_nxt,
   output logic             q_m1_nxt
);

   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] sum;

   assign m_ext = {m[WIDTH-1], m};

   always_comb begin
      sum = acc;
      case ({q[0], q_m1})
         2'b01:   sum = acc + m_ext;
         2'b10:   sum = acc - m_ext;
         default: sum = acc;
      endcase
   end

   assign acc_nxt  = {sum[WIDTH], sum[WIDTH:1]};
   assign q_nxt    = {sum[0], q[WIDTH-1:1]};
   assign q_m1_nxt = q[0];

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential signed Booth multiplier: done pulses WIDTH cycles after accept; start is ignored while busy (no queuing).
// Optional macro BOOTH_ZERO_SHORTCUT_EN: a zero operand finishes with P=0 in the cycle after accept.
module booth_seq_ctrl
   import booth_pkg::*;
#(
   parameter int WIDTH = BOOTH_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     M,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   P
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   state_e           state;
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] q;
   logic             q_m1;
   logic [WIDTH-1:0] m_reg;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   st_acc;
   logic [WIDTH-1:0] st_q;
   logic             st_qm1;
   logic [WIDTH-1:0] st_m;
   logic [WIDTH:0]   nx_acc;
   logic [WIDTH-1:0] nx_q;
   logic             nx_qm1;
   logic             zero_op;
   logic             last_step;

   // The accept edge already performs the first step from a cleared accumulator,
   // so RUN only needs WIDTH-1 cycles and the result lands in the WIDTH-th cycle.
   always_comb begin
      st_acc = acc;
      st_q   = q;
      st_qm1 = q_m1;
      st_m   = m_reg;
      if (state == IDLE) begin
         st_acc = '0;
         st_q   = A;
         st_qm1 = 1'b0;
         st_m   = M;
      end
   end

   booth_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc      (st_acc),
      .q        (st_q),
      .q_m1     (st_qm1),
      .m        (st_m),
      .acc_nxt  (nx_acc),
      .q_nxt    (nx_q),
      .q_m1_nxt (nx_qm1)
   );

`ifdef BOOTH_ZERO_SHORTCUT_EN
   assign zero_op = (A == '0) || (M == '0);
`else
   assign zero_op = 1'b0;
`endif

   assign last_step = (cnt == CW'(WIDTH - 2));
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         q     <= '0;
         q_m1  <= 1'b0;
         m_reg <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         P     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  m_reg <= M;
                  cnt   <= '0;
                  if (zero_op) begin
                     acc   <= '0;
                     q     <= '0;
                     q_m1  <= 1'b0;
                     P     <= '0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     acc   <= nx_acc;
                     q     <= nx_q;
                     q_m1  <= nx_qm1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               acc  <= nx_acc;
               q    <= nx_q;
               q_m1 <= nx_qm1;
               if (last_step) begin
                  P     <= {nx_acc[WIDTH-1:0], nx_q};
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
